// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command-driven sequencer for a bank of WIDTH negedge jk cells.
// Each posedge computes registered J/K drive from the fed-back q_vec to LOAD, SET,
// CLEAR, or count the bank UP/DOWN for a programmable number of steps. The bank
// applies a step on the following negedge, so one step completes per clk cycle.
//
// Ports:
//   clk        clock; controller acts on posedge
//   clr        asynchronous active-high reset (bank contents untouched)
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (IDLE only)
//   cmd_op     0 NOP, 1 LOAD, 2 UP, 3 DOWN, 4 CLEAR, 5 SET, 6-7 illegal
//   cmd_arg    load value (LOAD only)
//   cmd_steps  step count (UP/DOWN only)
//   q_vec      bank q outputs, bit i = cell i
//   j_vec      registered J drive to bank
//   k_vec      registered K drive to bank
//   busy       high while stepping
//   done       one-cycle completion pulse
//   err        pulses with done for an illegal opcode
module jk_bank_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPW = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic [WIDTH-1:0] q_vec,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OpLoad  = 3'd1;
  localparam logic [2:0] OpUp    = 3'd2;
  localparam logic [2:0] OpDown  = 3'd3;
  localparam logic [2:0] OpClear = 3'd4;
  localparam logic [2:0] OpSet   = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] arg_q;
  logic [STEPW-1:0] steps_q;  // steps still to register after the current one

  logic [WIDTH-1:0] up_t, dn_t;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_arg;
  logic [WIDTH-1:0] drv_j, drv_k;
  logic [STEPW-1:0] acc_steps;

  // Toggle masks: a bit flips when every lower bit is 1 (count up) or 0 (count down).
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      up_t[i] = up_t[i-1] & q_vec[i-1];
      dn_t[i] = dn_t[i-1] & ~q_vec[i-1];
    end
  end

  // On the accept edge the command is not latched yet, so drive from the live inputs.
  always_comb begin
    sel_op  = (state_q == StIdle) ? cmd_op : op_q;
    sel_arg = (state_q == StIdle) ? cmd_arg : arg_q;
    drv_j   = '0;
    drv_k   = '0;
    case (sel_op)
      OpLoad:  begin drv_j = sel_arg; drv_k = ~sel_arg; end
      OpUp:    begin drv_j = up_t;    drv_k = up_t;     end
      OpDown:  begin drv_j = dn_t;    drv_k = dn_t;     end
      OpClear: begin drv_j = '0;      drv_k = '1;       end
      OpSet:   begin drv_j = '1;      drv_k = '0;       end
      default: ;
    endcase
  end

  always_comb begin
    acc_steps = '0;
    case (cmd_op)
      OpLoad, OpClear, OpSet: acc_steps = STEPW'(1);
      OpUp, OpDown:           acc_steps = cmd_steps;
      default:                acc_steps = '0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      op_q      <= '0;
      arg_q     <= '0;
      steps_q   <= '0;
      j_vec     <= '0;
      k_vec     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            arg_q     <= cmd_arg;
            cmd_ready <= 1'b0;
            if (acc_steps != '0) begin
              steps_q <= acc_steps - STEPW'(1);
              j_vec   <= drv_j;
              k_vec   <= drv_k;
              busy    <= 1'b1;
              state_q <= StRun;
            end else begin
              steps_q <= '0;
              done    <= 1'b1;
              err     <= cmd_op[2] & cmd_op[1];  // ops 6 and 7
              state_q <= StDone;
            end
          end
        end
        StRun: begin
          if (steps_q != '0) begin
            steps_q <= steps_q - STEPW'(1);
            j_vec   <= drv_j;
            k_vec   <= drv_k;
          end else begin
            j_vec   <= '0;
            k_vec   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          j_vec     <= '0;
          k_vec     <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_seq.sv
// Testbench for jk_bank_seq: behavioural jk bank on the negedge, a driver that
// pushes expected completions into a scoreboard, and a monitor that checks step
// drive every busy cycle and pops/compares on every done pulse.
module tb_jk_bank_seq;
  localparam int W  = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          bank_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = '0;
  logic [W-1:0]  cmd_arg = '0;
  logic [SW-1:0] cmd_steps = '0;
  logic [W-1:0]  q_vec, j_vec, k_vec;
  logic          cmd_ready, busy, done, err;

  typedef struct {
    logic [W-1:0] q;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_q;
  logic [2:0]   cur_op = '0;
  logic [W-1:0] cur_arg = '0;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int busy_cnt = 0, n_done = 0, n_sent = 0;
  bit mon_en = 1'b0;

  jk_bank_seq #(.WIDTH(W), .STEPW(SW)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_steps(cmd_steps), .q_vec(q_vec),
    .j_vec(j_vec), .k_vec(k_vec), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // jk cell bank: q = J & ~q | ~K & q on the negedge
  always @(negedge clk or posedge bank_rst) begin
    if (bank_rst) q_vec <= '0;
    else          q_vec <= (j_vec & ~q_vec) | (~k_vec & q_vec);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(posedge clk) begin
    logic [W-1:0] ej, ek, qn;
    exp_t e;
    #1;
    if (clr) begin
      busy_cnt = 0;
    end else if (mon_en) begin
      if (busy) begin
        busy_cnt++;
        ej = '0; ek = '0;
        case (cur_op)
          3'd1: begin ej = cur_arg; ek = ~cur_arg; end
          3'd2: begin qn = q_vec + 1'b1; ej = q_vec ^ qn; ek = ej; end
          3'd3: begin qn = q_vec - 1'b1; ej = q_vec ^ qn; ek = ej; end
          3'd4: begin ej = '0; ek = '1; end
          3'd5: begin ej = '1; ek = '0; end
          default: ;
        endcase
        check("step_j", 32'(j_vec), 32'(ej));
        check("step_k", 32'(k_vec), 32'(ek));
      end else begin
        check("idle_j_zero", 32'(j_vec), 0);
        check("idle_k_zero", 32'(k_vec), 0);
      end
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done=1 required no pending command");
        end else begin
          e = sb.pop_front();
          check("done_q", 32'(q_vec), 32'(e.q));
          check("done_err", 32'(err), 32'(e.err));
          check("done_latency", 32'(cyc - e.acc), 32'(e.lat));
          check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
          check("done_ready_low", 32'(cmd_ready), 0);
        end
        busy_cnt = 0;
      end else begin
        check("err_without_done", 32'(err), 0);
      end
    end
  end

  // Present a command (valid stays high on return) and wait until it is accepted.
  task automatic send(input logic [2:0] op, input logic [W-1:0] arg, input logic [SW-1:0] steps,
                      input bit push, output int acc);
    int   s;
    int   guard;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_steps = steps;
    guard = 0;
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: got cmd_ready=0 required 1 within 2000 cycles");
      acc = -1;
      return;
    end
    acc = cyc + 1;
    cur_op = op; cur_arg = arg;
    case (op)
      3'd1: begin s = 1; model_q = arg; end
      3'd2: begin s = int'(steps); model_q = model_q + W'(steps); end
      3'd3: begin s = int'(steps); model_q = model_q - W'(steps); end
      3'd4: begin s = 1; model_q = '0; end
      3'd5: begin s = 1; model_q = '1; end
      default: s = 0;
    endcase
    if (push) begin
      e.q = model_q; e.err = (op >= 3'd6); e.lat = s; e.acc = acc;
      sb.push_back(e);
      n_sent++;
    end
    @(negedge clk);
  endtask

  task automatic drop();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a;
    model_q = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_j", 32'(j_vec), 0);
    check("rst_k", 32'(k_vec), 0);
    @(negedge clk);
    clr = 1'b0; bank_rst = 1'b0; mon_en = 1'b1;

    send(3'd1, 4'b1010, 8'd0, 1'b1, a); drop();
    send(3'd1, 4'b1110, 8'd0, 1'b1, a); drop();
    send(3'd2, 4'b0000, 8'd3, 1'b1, a); drop();
    send(3'd1, 4'b0001, 8'd0, 1'b1, a); drop();
    send(3'd3, 4'b0000, 8'd2, 1'b1, a); drop();
    send(3'd1, 4'b0101, 8'd0, 1'b1, a); drop();
    send(3'd2, 4'b1111, 8'd0, 1'b1, a); drop();
    send(3'd0, 4'b1111, 8'd9, 1'b1, a); drop();
    send(3'd7, 4'b0011, 8'd5, 1'b1, a); drop();

    // Back-to-back with valid held: SET must wait for DONE then IDLE.
    send(3'd4, 4'b0000, 8'd7, 1'b1, a1);
    send(3'd5, 4'b0000, 8'd7, 1'b1, a2);
    drop();
    check("b2b_accept_gap", 32'(a2 - a1), 3);

    // Asynchronous clear after 50 UP steps from 0.
    send(3'd4, 4'b0000, 8'd0, 1'b1, a); drop();
    send(3'd2, 4'b0000, 8'd200, 1'b0, a); drop();
    while (cyc < a + 49) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr_j", 32'(j_vec), 0);
    check("clr_k", 32'(k_vec), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_ready", 32'(cmd_ready), 1);
    check("clr_done", 32'(done), 0);
    check("clr_q", 32'(q_vec), 32'(50 % 16));
    @(negedge clk);
    #1 clr = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_q_held", 32'(q_vec), 32'(50 % 16));
    model_q = W'(50 % 16);

    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 7)), W'($urandom), SW'($urandom_range(0, 20)), 1'b1, a);
      if ($urandom_range(0, 1) == 1) drop();
    end
    drop();

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    check("done_count", 32'(n_done), 32'(n_sent));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
